// File: rtl/spi_frame_loader.sv
// SPI mode-0 slave that loads 1-bit RGB pixels into a 1024-entry frame buffer.
// Define LOADER_ECHO_EN to echo the previously completed byte on sdo.
module spi_frame_loader #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       sdi,
  input  logic       cs_n,
  output logic       sdo,
  output logic       we,
  output logic [9:0] adr_out,
  output logic       R_out,
  output logic       G_out,
  output logic       B_out,
  output logic       frame_done
);

  localparam int unsigned AW = 10;
  localparam int unsigned BW = 8;
  localparam logic [BW-1:0] CMD_FRAME = 8'hA0;
  localparam logic [BW-1:0] CMD_CONT  = 8'hA1;
  localparam logic [BW-1:0] CMD_ADDR  = 8'hB0;
  localparam logic [AW-1:0] ADDR_LAST = 10'h3FF;

  typedef enum logic [2:0] {IDLE, CMD, PIXEL, ADDR_HI, ADDR_LO, IGNORE} state_t;

  logic [SYNC_STAGES-1:0] sck_sync, sdi_sync, cs_sync;
  logic                   sck_prev, cs_prev;
  logic                   sck_s, sdi_s, cs_s;
  logic                   sck_rise, cs_fall;
  logic [2:0]             bit_cnt;
  logic [BW-1:0]          shreg;
  logic                   byte_valid;
  logic [AW-1:0]          addr;
  state_t                 state, state_next;
  logic                   write_c, clr_addr_c, ld_hi_c, ld_lo_c;

  // Input synchronizers, reset to the idle bus levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync <= '0;
      sdi_sync <= '0;
      cs_sync  <= '1;
      sck_prev <= 1'b0;
      cs_prev  <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sck_prev <= sck_s;
      cs_prev  <= cs_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign cs_fall  = ~cs_s & cs_prev;

  // Byte assembly; a deselect drops any partial byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
    end else if (cs_s) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (sck_rise) begin
        shreg      <= {shreg[BW-2:0], sdi_s};
        bit_cnt    <= bit_cnt + 3'd1;
        byte_valid <= (bit_cnt == 3'd7);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (cs_s) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (cs_fall) state_next = CMD;
        CMD: begin
          if (byte_valid) begin
            if (shreg == CMD_FRAME || shreg == CMD_CONT) state_next = PIXEL;
            else if (shreg == CMD_ADDR)                  state_next = ADDR_HI;
            else                                         state_next = IGNORE;
          end
        end
        ADDR_HI: if (byte_valid) state_next = ADDR_LO;
        ADDR_LO: if (byte_valid) state_next = PIXEL;
        default: state_next = state;
      endcase
    end
  end

  // A byte arriving as cs_n rises is dropped because cs_s already reads high
  always_comb begin
    write_c    = 1'b0;
    clr_addr_c = 1'b0;
    ld_hi_c    = 1'b0;
    ld_lo_c    = 1'b0;
    if (!cs_s && byte_valid) begin
      case (state)
        CMD:     clr_addr_c = (shreg == CMD_FRAME);
        ADDR_HI: ld_hi_c    = 1'b1;
        ADDR_LO: ld_lo_c    = 1'b1;
        PIXEL:   write_c    = 1'b1;
        default: ;
      endcase
    end
  end

  // Write port and address pointer; outputs hold between writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      we         <= 1'b0;
      adr_out    <= '0;
      R_out      <= 1'b0;
      G_out      <= 1'b0;
      B_out      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      we         <= write_c;
      frame_done <= write_c && (addr == ADDR_LAST);
      if (write_c) begin
        adr_out <= addr;
        R_out   <= shreg[0];
        G_out   <= shreg[1];
        B_out   <= shreg[2];
        addr    <= addr + 10'd1;
      end
      if (clr_addr_c) addr       <= '0;
      if (ld_hi_c)    addr[9:8]  <= shreg[1:0];
      if (ld_lo_c)    addr[7:0]  <= shreg;
    end
  end

`ifdef LOADER_ECHO_EN
  logic          sck_fall;
  logic [BW-1:0] echo;

  assign sck_fall = ~sck_s & sck_prev;

  // Reload on the falling edge after a byte boundary, otherwise shift MSB first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo <= '0;
    end else if (cs_s) begin
      echo <= '0;
    end else if (sck_fall) begin
      if (bit_cnt == 3'd0) echo <= shreg;
      else                 echo <= {echo[BW-2:0], 1'b0};
    end
  end

  assign sdo = echo[BW-1];
`else
  assign sdo = 1'b0;
`endif

endmodule

// File: doc/spi_frame_loader.md
SPI_FRAME_LOADER -- requirements
Module: spi_frame_loader

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on sck, sdi and cs_n (minimum 2).
REQ-002 clk  input  1  system clock; all logic on posedge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 sck  input  1  SPI clock from host MCU; asynchronous to clk; mode 0.
REQ-005 sdi  input  1  SPI data from host, MSB first.
REQ-006 cs_n  input  1  SPI chip select, active-low, frames one transaction.
REQ-007 sdo  output  1  SPI data to host (see Configuration).
REQ-008 we  output  1  frame-buffer write strobe, one clk wide per pixel.
REQ-009 adr_out  output  10  frame-buffer pixel address, 0..1023.
REQ-010 R_out, G_out, B_out  output  1 each  pixel colour for the write.
REQ-011 frame_done  output  1  one-clk pulse when address 1023 is written.

Function
REQ-012 sck, sdi and cs_n SHALL pass through SYNC_STAGES flops; sck rising edge detected from the last two synchronized samples.
REQ-013 Supported sck frequency SHALL be at most clk/4.
REQ-014 On each detected sck rise with cs_n low, synchronized sdi SHALL shift into an 8-bit register; the 8th bit completes a byte and asserts internal byte_valid for one clk.
REQ-015 cs_n high SHALL clear the bit counter, discard any partial byte, and return the FSM to IDLE.
REQ-016 FSM states: IDLE, CMD, PIXEL, ADDR_HI, ADDR_LO, IGNORE.
REQ-017 IDLE -> CMD when synchronized cs_n falls.
REQ-018 CMD on byte 0xA0 -> PIXEL with write address reset to 0; on 0xA1 -> PIXEL keeping current address; on 0xB0 -> ADDR_HI; any other byte -> IGNORE.
REQ-019 ADDR_HI: byte bits[1:0] SHALL become address[9:8], -> ADDR_LO; ADDR_LO: byte SHALL become address[7:0], -> PIXEL.
REQ-020 PIXEL: each byte SHALL produce one write: byte bits[0],[1],[2] -> R_out, G_out, B_out; bits[7:3] ignored.
REQ-021 we SHALL assert exactly one clk after byte_valid, with adr_out and colour stable during that cycle.
REQ-022 Address SHALL increment by 1 after each write, wrapping 1023 -> 0 without error.
REQ-023 frame_done SHALL assert in the same cycle as the we for address 1023.
REQ-024 IGNORE SHALL consume bytes with no writes until cs_n high.
REQ-025 cs_n rising in the same clk as byte_valid: the byte SHALL be discarded, no write.
REQ-026 we, adr_out and colour SHALL hold their last values when no write is in progress; we low.

Reset
REQ-027 rst_n low SHALL immediately force: FSM IDLE, bit counter 0, shift register 0, address 0, we 0, adr_out 0, R_out/G_out/B_out 0, frame_done 0, sdo 0, synchronizers to idle (sck 0, cs_n 1, sdi 0).
REQ-028 Reset mid-transaction SHALL abort it; no write SHALL occur until a new cs_n fall and command byte.

Configuration
REQ-029 Macro LOADER_ECHO_EN defined: sdo SHALL shift out, MSB first on sck falling edges, the byte last completed in the transaction (0x00 for the first byte), for host-side link check.
REQ-030 Macro LOADER_ECHO_EN undefined: sdo SHALL be constant 0 and the echo register SHALL not be built.

Verification
REQ-031 Reset, cs_n low, send 0xA0, 0x05, 0x02 -> writes adr 0 RGB=1,0,1 then adr 1 RGB=0,1,0; we exactly 2 pulses.
REQ-032 Send 0xB0, 0x03, 0xFF, 0x07, 0x01 -> write adr 1023 white with frame_done pulse, then adr 0 red (wrap).
REQ-033 Send 0xA0 then 1024 pixel bytes -> 1024 we pulses, addresses 0..1023 in order, frame_done once.
REQ-034 Send 0x55, 0x07 -> no we; then cs_n high, cs_n low, 0xA1, 0x04 -> write at address held before the transaction, blue.
REQ-035 Send 0xA0 then 5 bits, raise cs_n, reassert, send 0xA0, 0x01 -> only one write, adr 0, red; rst_n pulse mid-byte -> all outputs 0 immediately.
REQ-036 With LOADER_ECHO_EN: send 0xA0, 0x3C, 0x00 -> sdo returns 0x00, 0xA0, 0x3C; without macro sdo stays 0.
